// File: rtl/sensor_mem_arbiter.sv
// Arbitrates a single-port sensor SRAM between the AHB register-side bus and the capture engine.
// Capture has priority, but a bus request wins after MAX_CAP_STREAK consecutive capture grants.
module sensor_mem_arbiter #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned MAX_CAP_STREAK = 4
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              renable,
  input  logic              wenable,
  input  logic [15:0]       address,
  input  logic [15:0]       command_data,
  output logic              slave_wait,
  output logic [31:0]       sensor_data,
  input  logic              cap_req,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [15:0]       cap_data,
  output logic              cap_ack,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic              bus_overrun
);

  localparam logic [3:0] LP_MAX_STREAK = 4'(MAX_CAP_STREAK);

  typedef enum logic [2:0] {
    StIdle,
    StCap,
    StBwr,
    StBrd,
    StBrdWait
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_pend;
  logic              r_pend_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_data;
  logic [3:0]        r_streak;
  logic [31:0]       r_sensor_data;
  logic              r_bus_overrun;

  logic w_pulse;
  logic w_accept;
  logic w_bus_done;

  assign w_pulse    = renable | wenable;
  assign w_accept   = w_pulse & ~r_pend;
  assign w_bus_done = (r_state == StBwr) | (r_state == StBrdWait);

  // Upper address bits are outside the SRAM window and intentionally dropped.
  generate
    if (ADDR_W < 16) begin : g_addr_unused
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^address[15:ADDR_W];
    end
  endgenerate

  assign slave_wait  = r_pend | w_pulse;
  assign sensor_data = r_sensor_data;
  assign bus_overrun = r_bus_overrun;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_pend        <= 1'b0;
      r_pend_wr     <= 1'b0;
      r_addr        <= '0;
      r_data        <= '0;
      r_bus_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pend    <= 1'b1;
        r_pend_wr <= wenable;
        r_addr    <= address[ADDR_W-1:0];
        r_data    <= command_data;
      end else if (w_bus_done) begin
        r_pend <= 1'b0;
      end
      if (w_pulse && r_pend) begin
        r_bus_overrun <= 1'b1;
      end
    end
  end

  // Streak only counts capture grants taken while a bus request is waiting.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_streak <= '0;
    end else if (r_state == StCap) begin
      if (!r_pend) begin
        r_streak <= '0;
      end else if (r_streak != LP_MAX_STREAK) begin
        r_streak <= r_streak + 4'd1;
      end
    end else if (w_bus_done) begin
      r_streak <= '0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_sensor_data <= '0;
    end else if (r_state == StBrdWait) begin
      r_sensor_data <= {16'h0000, mem_rdata};
    end
  end

  always_comb begin
    w_next_state = r_state;
    cap_ack      = 1'b0;
    mem_cs       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (r_state)
      StIdle: begin
        if (r_pend && (!cap_req || (r_streak == LP_MAX_STREAK))) begin
          w_next_state = r_pend_wr ? StBwr : StBrd;
        end else if (cap_req) begin
          w_next_state = StCap;
        end
      end
      StCap: begin
        mem_cs       = 1'b1;
        mem_we       = 1'b1;
        mem_addr     = cap_addr;
        mem_wdata    = cap_data;
        cap_ack      = 1'b1;
        w_next_state = StIdle;
      end
      StBwr: begin
        mem_cs       = 1'b1;
        mem_we       = 1'b1;
        mem_addr     = r_addr;
        mem_wdata    = r_data;
        w_next_state = StIdle;
      end
      StBrd: begin
        mem_cs       = 1'b1;
        mem_addr     = r_addr;
        w_next_state = StBrdWait;
      end
      StBrdWait: begin
        w_next_state = StIdle;
      end
      default: begin
        w_next_state = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_sensor_mem_arbiter.sv
// Self-checking bench for sensor_mem_arbiter: a queue-based transaction model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_sensor_mem_arbiter;

  localparam int AW   = 8;
  localparam int MAXS = 4;

  localparam int OP_IDLE = 0;
  localparam int OP_CAP  = 1;
  localparam int OP_BWR  = 2;
  localparam int OP_BRD  = 3;
  localparam int OP_CAPT = 4;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic          renable = 1'b0;
  logic          wenable = 1'b0;
  logic [15:0]   address = 16'h0;
  logic [15:0]   command_data = 16'h0;
  logic          slave_wait;
  logic [31:0]   sensor_data;
  logic          cap_req = 1'b0;
  logic [AW-1:0] cap_addr = '0;
  logic [15:0]   cap_data = 16'h0;
  logic          cap_ack;
  logic          mem_cs;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata = 16'h0;
  logic          bus_overrun;

  sensor_mem_arbiter #(
    .ADDR_W         (AW),
    .MAX_CAP_STREAK (MAXS)
  ) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .renable      (renable),
    .wenable      (wenable),
    .address      (address),
    .command_data (command_data),
    .slave_wait   (slave_wait),
    .sensor_data  (sensor_data),
    .cap_req      (cap_req),
    .cap_addr     (cap_addr),
    .cap_data     (cap_data),
    .cap_ack      (cap_ack),
    .mem_cs       (mem_cs),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .bus_overrun  (bus_overrun)
  );

  always #5 HCLK = ~HCLK;

  // SRAM environment, written and read only through the DUT's strobes
  logic [15:0] sram [256];
  always @(posedge HCLK) begin
    if (mem_cs) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_word(input int i);
    return (i == 9) ? 16'h0CAB : 16'((i * 16'h1357) ^ 16'hA5C3);
  endfunction

  // Reference model: pending bus request, streak count, and a queue of scheduled
  // memory operations for the coming cycles.
  logic [15:0] m_mem [256];
  int          m_q[$];
  bit          m_pend;
  bit          m_pend_wr;
  logic [7:0]  m_addr;
  logic [15:0] m_data;
  int          m_streak;
  logic [31:0] m_sensor;
  bit          m_overrun;

  always @(negedge HCLK) begin
    int          op;
    bit          old_pend;
    logic        e_cs, e_we, e_ack;
    logic [7:0]  e_addr;
    logic [15:0] e_wdata;
    if (HRESET) begin
      m_q.delete();
      m_pend    = 0;
      m_pend_wr = 0;
      m_streak  = 0;
      m_sensor  = 32'h0;
      m_overrun = 0;
      check("rst_outs", {cap_ack, mem_cs, mem_we, bus_overrun}, 32'h0);
      check("rst_mem_bus", {mem_addr, mem_wdata}, 32'h0);
      check("rst_sensor", sensor_data, 32'h0);
      check("rst_wait", slave_wait, 32'(renable | wenable));
    end else begin
      op = (m_q.size() > 0) ? m_q.pop_front() : OP_IDLE;
      e_cs = 0; e_we = 0; e_ack = 0; e_addr = 8'h0; e_wdata = 16'h0;
      if (op == OP_CAP) begin
        e_cs = 1; e_we = 1; e_ack = 1; e_addr = cap_addr; e_wdata = cap_data;
      end else if (op == OP_BWR) begin
        e_cs = 1; e_we = 1; e_addr = m_addr; e_wdata = m_data;
      end else if (op == OP_BRD) begin
        e_cs = 1; e_addr = m_addr;
      end
      check("mdl_strobes", {cap_ack, mem_cs, mem_we}, {29'h0, e_ack, e_cs, e_we});
      check("mdl_addr", 32'(mem_addr), 32'(e_addr));
      if (e_we) check("mdl_wdata", 32'(mem_wdata), 32'(e_wdata));
      check("mdl_wait", 32'(slave_wait), 32'(m_pend | renable | wenable));
      check("mdl_sensor", sensor_data, m_sensor);
      check("mdl_overrun", 32'(bus_overrun), 32'(m_overrun));

      old_pend = m_pend;
      case (op)
        OP_CAP: begin
          m_mem[cap_addr] = cap_data;
          m_streak = old_pend ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
        end
        OP_BWR: begin
          m_mem[m_addr] = m_data;
          m_pend = 0;
          m_streak = 0;
        end
        OP_CAPT: begin
          m_sensor = {16'h0, m_mem[m_addr]};
          m_pend = 0;
          m_streak = 0;
        end
        OP_IDLE: begin
          if (old_pend && (!cap_req || m_streak == MAXS)) begin
            if (m_pend_wr) m_q.push_back(OP_BWR);
            else begin
              m_q.push_back(OP_BRD);
              m_q.push_back(OP_CAPT);
            end
          end else if (cap_req) begin
            m_q.push_back(OP_CAP);
          end
        end
        default: ;
      endcase
      if (renable | wenable) begin
        if (old_pend) m_overrun = 1;
        else begin
          m_pend    = 1;
          m_pend_wr = wenable;
          m_addr    = address[7:0];
          m_data    = command_data;
        end
      end
    end
  end

  logic last_ack = 1'b0;
  always @(negedge HCLK) last_ack <= cap_ack;

  task automatic bus_pulse(input bit rd, input bit wr, input logic [15:0] a,
                           input logic [15:0] d);
    @(posedge HCLK); #1;
    renable = rd; wenable = wr; address = a; command_data = d;
  endtask

  task automatic bus_clear();
    @(posedge HCLK); #1;
    renable = 0; wenable = 0;
  endtask

  initial begin
    int  n_ack;
    bit  found;
    for (int i = 0; i < 256; i++) begin
      sram[i]  = init_word(i);
      m_mem[i] = init_word(i);
    end
    HRESET = 1;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 0;
    repeat (2) @(negedge HCLK);
    check("idle_outs", {slave_wait, cap_ack, mem_cs, mem_we, bus_overrun}, 32'h0);
    check("idle_sensor", sensor_data, 32'h0);

    // Reset in the middle of a read drops it without any further strobe.
    bus_pulse(1, 0, 16'h0009, 16'h0);
    @(negedge HCLK);
    bus_clear();
    @(posedge HCLK); #1;
    check("brd_before_rst", {mem_cs, mem_we, mem_addr}, {22'h0, 1'b1, 1'b0, 8'h09});
    HRESET = 1;
    #1;
    check("rst_mid_cs", 32'(mem_cs), 32'h0);
    check("rst_mid_wait", 32'(slave_wait), 32'h0);
    check("rst_mid_sensor", sensor_data, 32'h0);
    @(posedge HCLK); #1 HRESET = 0;
    repeat (3) begin
      @(negedge HCLK);
      check("rst_no_strobe", {mem_cs, slave_wait}, 32'h0);
    end

    // Uncontended write
    bus_pulse(0, 1, 16'h001F, 16'hF397);
    @(negedge HCLK);
    check("wr_wait_c0", 32'(slave_wait), 32'h1);
    bus_clear();
    @(negedge HCLK);
    check("wr_c1", {slave_wait, mem_cs}, 32'h2);
    @(negedge HCLK);
    check("wr_mem_c2", {mem_cs, mem_we, mem_addr, mem_wdata}, {6'h0, 1'b1, 1'b1, 8'h1F, 16'hF397});
    check("wr_wait_c2", 32'(slave_wait), 32'h1);
    @(negedge HCLK);
    check("wr_c3", {slave_wait, mem_cs}, 32'h0);

    // Uncontended read
    bus_pulse(1, 0, 16'h0009, 16'h0);
    @(negedge HCLK);
    bus_clear();
    @(negedge HCLK);
    @(negedge HCLK);
    check("rd_mem_c2", {mem_cs, mem_we, mem_addr}, {22'h0, 1'b1, 1'b0, 8'h09});
    @(negedge HCLK);
    check("rd_c3", {slave_wait, mem_cs}, 32'h2);
    @(negedge HCLK);
    check("rd_data_c4", sensor_data, 32'h00000CAB);
    check("rd_wait_c4", 32'(slave_wait), 32'h0);

    // renable and wenable together count as a write
    bus_pulse(1, 1, 16'h0042, 16'h1234);
    @(negedge HCLK);
    bus_clear();
    @(negedge HCLK);
    @(negedge HCLK);
    check("both_wr_c2", {mem_cs, mem_we, mem_addr, mem_wdata}, {6'h0, 1'b1, 1'b1, 8'h42, 16'h1234});
    @(negedge HCLK);
    @(negedge HCLK);
    check("both_no_read", sensor_data, 32'h00000CAB);

    // Second pulse while pending is dropped and flagged
    bus_pulse(0, 1, 16'h0050, 16'h1111);
    @(negedge HCLK);
    bus_pulse(0, 1, 16'h0051, 16'h2222);
    @(negedge HCLK);
    check("ovr_c1", 32'(bus_overrun), 32'h0);
    bus_clear();
    @(negedge HCLK);
    check("ovr_set", 32'(bus_overrun), 32'h1);
    check("ovr_first_wr", {mem_cs, mem_we, mem_addr, mem_wdata}, {6'h0, 1'b1, 1'b1, 8'h50, 16'h1111});
    repeat (4) begin
      @(negedge HCLK);
      check("ovr_no_second", 32'(mem_cs), 32'h0);
    end
    check("ovr_sticky", 32'(bus_overrun), 32'h1);

    // Continuous capture vs. a bus read: streak limit lets the read through
    @(posedge HCLK); #1;
    cap_req = 1; cap_addr = 8'h30; cap_data = 16'hBEEF;
    repeat (3) @(posedge HCLK);
    #1 renable = 1; address = 16'h0077;
    @(negedge HCLK);
    bus_clear();
    n_ack = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge HCLK);
      if (mem_cs && !mem_we) found = 1;
      else if (cap_ack) n_ack++;
    end
    check("streak_read_granted", 32'(found), 32'h1);
    check("streak_acks", n_ack, 4);
    check("streak_rd_addr", 32'(mem_addr), 32'h77);
    @(negedge HCLK);
    @(negedge HCLK);
    check("streak_rd_data", sensor_data, {16'h0, init_word(8'h77)});
    found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge HCLK);
      if (cap_ack) found = 1;
    end
    check("cap_resumes", 32'(found), 32'h1);
    @(posedge HCLK); #1 cap_req = 0;
    repeat (3) @(posedge HCLK);

    // Random traffic against the model, with one reset in the middle
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge HCLK); #1;
      renable = 0; wenable = 0;
      if (cyc == 1500) HRESET = 1;
      if (cyc == 1502) HRESET = 0;
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0, 1: renable = 1;
          2: wenable = 1;
          default: begin renable = 1; wenable = 1; end
        endcase
        address = {8'($urandom), 4'h0, 4'($urandom)};
        command_data = 16'($urandom);
      end
      if (cap_req && last_ack) cap_req = 0;
      if (!cap_req && $urandom_range(0, 2) == 0) begin
        cap_req  = 1;
        cap_addr = 8'($urandom_range(0, 15));
        cap_data = 16'($urandom);
      end
    end
    @(posedge HCLK); #1;
    renable = 0; wenable = 0; cap_req = 0;
    repeat (6) @(posedge HCLK);
    check("end_idle", {slave_wait, mem_cs}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sensor_mem_arbiter.md
Name: sensor_mem_arbiter

Overview:
- Sits between the AHB slave's register-side interface (renable/wenable/address/command_data, slave_wait/sensor_data) and a single-port sensor SRAM.
- Shares that SRAM with the sensor capture engine, which writes samples into it.
- Sequences one memory access per grant and holds the bus side stalled via slave_wait until the access completes.
- Capture normally has priority; a streak limit prevents bus starvation.

Parameters:
- ADDR_W, 8: SRAM address width; mem_addr is the low ADDR_W bits of the selected address.
- MAX_CAP_STREAK, 4: maximum consecutive capture grants while a bus request is pending; range 1..15.

Ports:
- HCLK  in  1  system clock, rising edge.
- HRESET  in  1  asynchronous reset, active-high.
- renable  in  1  bus read request pulse, one cycle.
- wenable  in  1  bus write request pulse, one cycle.
- address  in  16  bus address, sampled with the pulse.
- command_data  in  16  bus write data, sampled with the pulse.
- slave_wait  out  1  bus stall (HREADYOUT = !slave_wait).
- sensor_data  out  32  bus read data, {16'h0, word}, registered.
- cap_req  in  1  capture write request; level, held until acked.
- cap_addr  in  ADDR_W  capture address, stable while cap_req is high.
- cap_data  in  16  capture data, stable while cap_req is high.
- cap_ack  out  1  one-cycle grant/completion of a capture write.
- mem_cs  out  1  SRAM chip select.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  16  SRAM write data.
- mem_rdata  in  16  SRAM read data; valid the cycle after a read with mem_cs=1, mem_we=0.
- bus_overrun  out  1  sticky: a bus pulse arrived while a request was already pending.

Behaviour:
- Reset (async, HRESET=1):
  - state=IDLE; pend, pend_wr, streak cleared.
  - sensor_data=0, bus_overrun=0, cap_ack=0, mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - slave_wait is 0 once combinational inputs are low.
  - Reset mid-operation drops any pending or in-flight access; no memory strobe is issued.
- Bus capture:
  - On a cycle with renable|wenable and pend=0: at the clock edge, latch address[ADDR_W-1:0], command_data, and pend_wr=wenable; set pend=1.
  - renable and wenable together: treated as a write.
  - A pulse while pend=1 is ignored and sets bus_overrun.
- slave_wait = pend | renable | wenable (combinational OR with registered pend). It drops the cycle after pend clears.
- FSM states: IDLE, CAP, BWR, BRD, BRD_WAIT. Every non-IDLE state lasts exactly one cycle.
- IDLE transitions:
  - If pend and (!cap_req or streak==MAX_CAP_STREAK): go to BWR when pend_wr, else BRD.
  - Else if cap_req: go to CAP.
  - Else stay in IDLE.
  - The decision uses registered pend only; a pulse in the current cycle is not granted until the next IDLE evaluation.
- CAP: mem_cs=1, mem_we=1, mem_addr=cap_addr, mem_wdata=cap_data, cap_ack=1. Next state IDLE.
  - streak increments (saturating) if pend=1; otherwise it is cleared.
- BWR: mem_cs=1, mem_we=1, latched addr/data driven. pend and streak clear at the edge. Next state IDLE.
- BRD: mem_cs=1, mem_we=0, latched addr driven. Next state BRD_WAIT.
- BRD_WAIT: mem_cs=0. sensor_data <= {16'h0, mem_rdata}; pend and streak clear at the edge. Next state IDLE.
- Latency, uncontended:
  - Write: pulse at cycle 0 → BWR at cycle 2 → slave_wait=0 at cycle 3.
  - Read: pulse at cycle 0 → BRD at 2, BRD_WAIT at 3 → sensor_data valid and slave_wait=0 at cycle 4.
- Memory outputs are 0 in IDLE and BRD_WAIT.
- Capture is never granted back-to-back without passing through IDLE; its sustained rate is 1 write per 2 cycles.
- sensor_data holds its value until the next completed bus read.

Test Plan:
- Reset, then idle with HRESET=0 → all outputs 0; assert HRESET mid-BRD → state IDLE, mem_cs=0, slave_wait=0, sensor_data unchanged from 0.
- wenable, address=16'h001F, command_data=16'hF397, no cap_req → cycle 2: mem_cs=1, mem_we=1, mem_addr=8'h1F, mem_wdata=16'hF397; slave_wait high during cycles 0-2, low at 3.
- SRAM model holds 16'h0CAB at 8'h09; renable, address=16'h0009 → mem read at cycle 2; sensor_data=32'h00000CAB and slave_wait=0 at cycle 4.
- cap_req held continuously (cap_addr=8'h30, cap_data=16'hBEEF) while renable is pulsed → exactly 4 cap_ack pulses, then the bus read is granted; streak clears and capture resumes afterwards.
- renable and wenable high in the same cycle → write performed, no read.
- Second wenable while pend=1 → ignored; bus_overrun=1 and stays set until reset.
